// File: rtl/approx_log_divider_pipe.sv
// Mitchell log-domain approximate signed 8-bit divider, Q8.8 quotient.
// Three registered stages (log/LOD, log subtract, antilog) with a global stall.
module approx_log_divider_pipe #(
    parameter int TRUNC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  A,
    input  logic signed [7:0]  B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        quotient,
    output logic               dbz,
    output logic               sat
);

    localparam int F  = TRUNC_W - 1;   // fraction bits kept in the log word
    localparam int LW = F + 3;         // {k, x_t}
    localparam int DW = F + 4;         // signed log difference

    // Log word {k, x_t}: leading-one index plus truncated mantissa fraction.
    function automatic logic [LW-1:0] f_log(input logic [7:0] m);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) k = 3'(i);
        return {k, F'(8'(m << (3'd7 - k)) >> (7 - F))};
    endfunction

    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ---------------- stage 1: sign, magnitude, LOD ----------------
    logic [7:0] w_abs_a, w_abs_b;
    assign w_abs_a = A[7] ? (~A + 8'd1) : A;
    assign w_abs_b = B[7] ? (~B + 8'd1) : B;

    logic          r1_vld, r1_sign, r1_za, r1_zb, r1_aneg;
    logic [LW-1:0] r1_la, r1_lb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld  <= 1'b0;
            r1_sign <= 1'b0;
            r1_za   <= 1'b0;
            r1_zb   <= 1'b0;
            r1_aneg <= 1'b0;
            r1_la   <= '0;
            r1_lb   <= '0;
        end else if (w_en) begin
            r1_vld  <= in_valid;
            r1_sign <= A[7] ^ B[7];
            r1_za   <= (A == 8'sd0);
            r1_zb   <= (B == 8'sd0);
            r1_aneg <= A[7];
            r1_la   <= f_log(w_abs_a);
            r1_lb   <= f_log(w_abs_b);
        end
    end

    // ---------------- stage 2: log difference ----------------
    logic signed [DW-1:0] w_d;
    assign w_d = $signed({1'b0, r1_la}) - $signed({1'b0, r1_lb});

    logic                 r2_vld, r2_sign, r2_za, r2_zb, r2_aneg;
    logic signed [DW-1:0] r2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_vld  <= 1'b0;
            r2_sign <= 1'b0;
            r2_za   <= 1'b0;
            r2_zb   <= 1'b0;
            r2_aneg <= 1'b0;
            r2_d    <= '0;
        end else if (w_en) begin
            r2_vld  <= r1_vld;
            r2_sign <= r1_sign;
            r2_za   <= r1_za;
            r2_zb   <= r1_zb;
            r2_aneg <= r1_aneg;
            r2_d    <= w_d;
        end
    end

    // ---------------- stage 3: antilog, saturation, specials ----------------
    // Upper 4 bits of d are floor(d) in two's complement; low F bits are frac(d).
    logic signed [4:0] w_shamt;
    logic [3:0]        w_lsh, w_rsh;
    logic [23:0]       w_man, w_mag;
    logic [15:0]       w_q;
    logic              w_dbz, w_sat;

    assign w_shamt = 5'({r2_d[DW-1], r2_d[DW-1:F]} + 5'd8 - 5'(F));
    assign w_lsh   = w_shamt[3:0];
    assign w_rsh   = 4'(-w_shamt);
    assign w_man   = 24'({1'b1, r2_d[F-1:0]});
    assign w_mag   = w_shamt[4] ? (w_man >> w_rsh) : (w_man << w_lsh);

    always_comb begin
        w_q   = '0;
        w_dbz = 1'b0;
        w_sat = 1'b0;
        if (r2_zb) begin
            w_dbz = 1'b1;
            w_q   = r2_aneg ? 16'h8000 : 16'h7FFF;
        end else if (r2_za) begin
            w_q   = '0;
        end else if (!r2_sign && w_mag > 24'd32767) begin
            w_q   = 16'h7FFF;
            w_sat = 1'b1;
        end else if (r2_sign && w_mag > 24'd32768) begin
            w_q   = 16'h8000;
            w_sat = 1'b1;
        end else begin
            w_q   = r2_sign ? (~w_mag[15:0] + 16'd1) : w_mag[15:0];
        end
    end

    logic        r3_vld, r3_dbz, r3_sat;
    logic [15:0] r3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r3_vld <= 1'b0;
            r3_q   <= '0;
            r3_dbz <= 1'b0;
            r3_sat <= 1'b0;
        end else if (w_en) begin
            r3_vld <= r2_vld;
            r3_q   <= r2_vld ? w_q : 16'h0000;
            r3_dbz <= r2_vld & w_dbz;
            r3_sat <= r2_vld & w_sat;
        end
    end

    assign out_valid = r3_vld;
    assign quotient  = r3_q;
    assign dbz       = r3_dbz;
    assign sat       = r3_sat;

endmodule

// File: tb/tb_approx_log_divider_pipe.sv
// Directed bench for approx_log_divider_pipe (TRUNC_W=4): vector table,
// backpressure ordering/hold sequence and mid-flight reset sequence.
module tb_approx_log_divider_pipe;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, out_valid, out_ready, dbz, sat;
    logic signed [7:0] A, B;
    logic [15:0]       quotient;

    int n_tests = 0;
    int n_fail  = 0;

    approx_log_divider_pipe #(.TRUNC_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .dbz(dbz), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] q;
        logic        dbz;
        logic        sat;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after the accepting edge; returns edges until out_valid.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Output-side monitor used during the backpressure sequence.
    logic        mon_on = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_q = '0;
    logic [15:0] rxq[$];
    logic        rxd[$];

    always @(negedge clk) begin
        if (mon_on) begin
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (prev_stall && out_valid) chk("stall_hold", 32'(quotient), 32'(prev_q));
            if (out_valid && out_ready) begin
                rxq.push_back(quotient);
                rxd.push_back(dbz);
            end
            prev_stall = out_valid && !out_ready;
            prev_q     = quotient;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    logic [7:0]  bp_a[4];
    logic [15:0] bp_q[4];
    logic [7:0]  bp_b[4];
    logic        bp_d[4];

    initial begin
        int lat;
        int idx;

        vt[0]  = '{8'd64,  8'd8,   16'h0800, 1'b0, 1'b0};
        vt[1]  = '{8'd6,   8'd4,   16'h0180, 1'b0, 1'b0};
        vt[2]  = '{8'd3,   8'hFA,  16'hFF80, 1'b0, 1'b0};
        vt[3]  = '{8'd127, 8'd1,   16'h7800, 1'b0, 1'b0};
        vt[4]  = '{8'h80,  8'd1,   16'h8000, 1'b0, 1'b0};
        vt[5]  = '{8'h80,  8'hFF,  16'h7FFF, 1'b0, 1'b1};
        vt[6]  = '{8'd5,   8'd0,   16'h7FFF, 1'b1, 1'b0};
        vt[7]  = '{8'hFB,  8'd0,   16'h8000, 1'b1, 1'b0};
        vt[8]  = '{8'd0,   8'd9,   16'h0000, 1'b0, 1'b0};
        vt[9]  = '{8'd0,   8'd0,   16'h7FFF, 1'b1, 1'b0};
        vt[10] = '{8'd1,   8'd127, 16'h0002, 1'b0, 1'b0};
        vt[11] = '{8'hFF,  8'd1,   16'hFF00, 1'b0, 1'b0};
        vt[12] = '{8'd100, 8'hFD,  16'hE000, 1'b0, 1'b0};
        vt[13] = '{8'd1,   8'h80,  16'hFFFE, 1'b0, 1'b0};
        vt[14] = '{8'hF9,  8'hFE,  16'h0380, 1'b0, 1'b0};
        vt[15] = '{8'd127, 8'hFF,  16'h8800, 1'b0, 1'b0};

        bp_a[0] = 8'd64; bp_b[0] = 8'd8;  bp_q[0] = 16'h0800; bp_d[0] = 1'b0;
        bp_a[1] = 8'hF9; bp_b[1] = 8'hFE; bp_q[1] = 16'h0380; bp_d[1] = 1'b0;
        bp_a[2] = 8'd3;  bp_b[2] = 8'hFA; bp_q[2] = 16'hFF80; bp_d[2] = 1'b0;
        bp_a[3] = 8'd5;  bp_b[3] = 8'd0;  bp_q[3] = 16'h7FFF; bp_d[3] = 1'b1;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient",  32'(quotient),  32'd0);
        chk("rst_dbz",       32'(dbz),       32'd0);
        chk("rst_sat",       32'(sat),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;

        // Table: one op at a time, latency and result per vector.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; A = vt[i].a; B = vt[i].b;
            @(posedge clk); #1;
            in_valid = 1'b0;
            wait_out(lat);
            chk($sformatf("lat[%0d]", i), 32'(lat), 32'd2);
            chk($sformatf("q[%0d]", i),   32'(quotient), 32'(vt[i].q));
            chk($sformatf("dbz[%0d]", i), 32'(dbz), 32'(vt[i].dbz));
            chk($sformatf("sat[%0d]", i), 32'(sat), 32'(vt[i].sat));
        end
        @(posedge clk); #1;
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back ops with out_ready low in cycles 4..8.
        mon_on = 1'b1;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (idx < 4);
            if (idx < 4) begin A = bp_a[idx]; B = bp_b[idx]; end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1; mon_on = 1'b0;
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_count", 32'(rxq.size()), 32'd4);
        for (int j = 0; j < 4 && j < rxq.size(); j++) begin
            chk($sformatf("bp_q[%0d]", j),   32'(rxq[j]), 32'(bp_q[j]));
            chk($sformatf("bp_dbz[%0d]", j), 32'(rxd[j]), 32'(bp_d[j]));
        end

        // Reset with two ops in flight, then a lone op afterwards.
        in_valid = 1'b1; A = 8'd64; B = 8'd8;
        @(posedge clk); #1;
        A = 8'd6; B = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quotient",  32'(quotient),  32'd0);
        in_valid = 1'b1; A = 8'd1; B = 8'h80;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("postrst_lat", 32'(lat), 32'd2);
        chk("postrst_q",   32'(quotient), 32'hFFFE);
        @(posedge clk); #1;
        chk("postrst_alone", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
